// File: rtl/tri_bus_pkg.sv
// Shared types and helpers for the multi-channel tri-state bus driver.
// Contents: FSM state enum (IDLE/DRIVE/TURN), onehot() index decoder.
// No ports; imported by rr_arb and tri_bus_drv.
package tri_bus_pkg;

  // Widest channel count the onehot() helper can decode.
  localparam int unsigned MAX_N = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_e;

  // Decode an index into a one-hot vector; out-of-range indices give zero.
  // Callers size-cast the result down to their own channel count.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] r;
    r = '0;
    if (idx < n && idx < MAX_N) begin
      r = MAX_N'(1) << idx;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Rotating-priority encoder: picks the first asserted req at or after ptr,
// wrapping from channel N-1 back to 0. Purely combinational, zero latency.
// Ports: req_i (N), ptr_i (index), any_req_o, win_o (index of the winner).
module rr_arb #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          any_req_o,
  output logic [PW-1:0] win_o
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    idx   = ptr_i;
    found = 1'b0;
    win_o = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win_o = idx;
      end
      // Explicit wrap so non-power-of-two N never visits a phantom channel.
      idx = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
    end
    any_req_o = found;
  end

endmodule

// File: rtl/tri_bus_drv.sv
// N-requester round-robin driver of one shared tri-state bus with a
// registered data path, bounded bursts and a guaranteed high-Z turnaround.
// Ports: clk, rst (sync, active-high), enable, req[N], din[N*W],
//        grant[N] (one-hot owner), oe, DOUT (tri). Optional PAR (tri) when
//        TRI_BUS_PARITY_EN is defined: even parity of the driven data.
module tri_bus_drv
  import tri_bus_pkg::*;
#(
  parameter int W         = 8,
  parameter int N         = 4,
  parameter int MAX_BURST = 4,
  parameter int TURN_CYC  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  output logic [N-1:0]   grant,
  output logic           oe,
  output tri   [W-1:0]   DOUT
`ifdef TRI_BUS_PARITY_EN
  ,
  output tri             PAR
`endif
);

  localparam int PW  = $clog2(N);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam int TCW = $clog2(TURN_CYC + 1);

  state_e        state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  dreg_q, dreg_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [TCW-1:0] turn_q, turn_d;

  logic          any_req;
  logic [PW-1:0] win;
  logic [W-1:0]  din_a [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign din_a[g] = din[g*W +: W];
  end

  rr_arb #(.N(N), .PW(PW)) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .any_req_o (any_req),
    .win_o     (win)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    dreg_d  = dreg_q;
    burst_d = burst_q;
    turn_d  = turn_q;
    case (state_q)
      IDLE: begin
        if (enable && any_req) begin
          state_d = DRIVE;
          owner_d = win;
          dreg_d  = din_a[win];
          burst_d = BW'(1);
        end
      end
      DRIVE: begin
        if (enable && req[owner_q] && (burst_q < BW'(MAX_BURST))) begin
          dreg_d  = din_a[owner_q];
          burst_d = burst_q + BW'(1);
        end else begin
          // Tenure ends; dreg holds its value but is no longer driven.
          state_d = TURN;
          turn_d  = TCW'(1);
          ptr_d   = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);
        end
      end
      TURN: begin
        if (turn_q < TCW'(TURN_CYC)) begin
          turn_d = turn_q + TCW'(1);
        end else if (enable && any_req) begin
          state_d = DRIVE;
          owner_d = win;
          dreg_d  = din_a[win];
          burst_d = BW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      dreg_q  <= '0;
      burst_q <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      dreg_q  <= dreg_d;
      burst_q <= burst_d;
      turn_q  <= turn_d;
    end
  end

  // oe and grant decode straight from registered state, so they change
  // on the same edge as dreg and the bus never sees a combinational glitch.
  assign oe    = (state_q == DRIVE);
  assign grant = oe ? N'(onehot(int'(owner_q), N)) : '0;
  assign DOUT  = oe ? dreg_q : {W{1'bz}};

`ifdef TRI_BUS_PARITY_EN
  logic par_q;

  // Parity is captured from the same mux output as dreg so both align.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^dreg_d;
    end
  end

  assign PAR = oe ? par_q : 1'bz;
`endif

endmodule

// File: tb/tb_tri_bus_drv.sv
module tb_tri_bus_drv;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int TC = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  wire  [N-1:0]   grant;
  wire            oe;
  wire  [W-1:0]   dout;
`ifdef TRI_BUS_PARITY_EN
  wire            par;
`endif

  always #5 clk = ~clk;

  tri_bus_drv #(.W(W), .N(N), .MAX_BURST(MB), .TURN_CYC(TC)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .req    (req),
    .din    (din),
    .grant  (grant),
    .oe     (oe),
    .DOUT   (dout)
`ifdef TRI_BUS_PARITY_EN
    ,
    .PAR    (par)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the bus, how long they have held it, how many
  // idle cycles have elapsed since the last tenure, and where the search starts.
  int           m_owner = -1;
  int           m_len   = 0;
  int           m_gap   = 0;
  int           m_ptr   = 0;
  logic [W-1:0] m_data  = '0;

  function automatic logic [W-1:0] chan_data(input int ch);
    return din[ch*W +: W];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_owner = -1; m_len = 0; m_gap = 0; m_ptr = 0; m_data = '0;
    end else if (m_owner >= 0) begin
      if (enable && req[m_owner] && m_len < MB) begin
        m_len++;
        m_data = chan_data(m_owner);
      end else begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1;
      end
    end else if (m_gap > 0 && m_gap < TC) begin
      m_gap++;
    end else begin
      m_gap = 0;
      if (enable && (req != 0)) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (m_owner < 0 && req[c]) m_owner = c;
        end
        m_len  = 1;
        m_data = chan_data(m_owner);
      end
    end
  endtask

  task automatic step(input string tag);
    logic [N-1:0] eg;
    @(posedge clk);
    model_edge();
    #1;
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    check({tag, "/oe"}, oe, m_owner >= 0);
    check({tag, "/grant"}, grant, eg);
    if (m_owner >= 0) begin
      check({tag, "/dout"}, dout, m_data);
`ifdef TRI_BUS_PARITY_EN
      check({tag, "/par"}, par, ^m_data);
`endif
    end
  endtask

  task automatic set_din(input int ch, input logic [W-1:0] v);
    din[ch*W +: W] = v;
  endtask

  logic [W-1:0] sc_vals [5] = '{8'h00, 8'hff, 8'h55, 8'haa, 8'h11};
  logic [N-1:0] rr_exp [16] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
                                4'b0001};

  initial begin
    rst = 1'b1; enable = 1'b0; req = '0; din = '0;
    step("reset"); step("reset");
    check("reset_oe", oe, 1'b0);
    check("reset_grant", grant, '0);

    rst = 1'b0; enable = 1'b1;
    repeat (5) begin
      step("idle");
      check("idle_grant", grant, '0);
    end

    // Single channel, held request: four beats, one gap, regrant.
    req = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      set_din(1, sc_vals[k]);
      step("single");
      check("single_dout", dout, sc_vals[k]);
    end
    set_din(1, sc_vals[4]);
    step("single_gap");
    check("single_gap_oe", oe, 1'b0);
    step("single_regrant");
    check("single_regrant_dout", dout, 8'h11);
    check("single_regrant_grant", grant, 4'b0010);

    // Round robin over channels 0,1,3 from a fresh pointer.
    req = '0; rst = 1'b1; step("rst"); rst = 1'b0;
    req = 4'b1011;
    for (int k = 0; k < 16; k++) begin
      din = {$urandom, $urandom};
      step("rr");
      check("rr_seq", grant, rr_exp[k]);
    end

    // Early release after two beats.
    req = '0; rst = 1'b1; step("rst"); rst = 1'b0;
    req = 4'b0100;
    set_din(2, 8'h3c); step("early"); check("early_d0", dout, 8'h3c);
    set_din(2, 8'hc3); step("early"); check("early_d1", dout, 8'hc3);
    req = '0;
    step("early_end");
    check("early_end_grant", grant, '0);

    // Enable gating.
    enable = 1'b0; req = 4'b1111;
    repeat (3) begin
      step("gate");
      check("gate_grant", grant, '0);
    end
    enable = 1'b1;
    step("gate_on"); step("gate_on");
    enable = 1'b0;
    step("gate_drop");
    check("gate_drop_oe", oe, 1'b0);
    enable = 1'b1;

    // Reset while driving.
    step("pre_rst"); step("pre_rst");
    check("pre_rst_oe", oe, 1'b1);
    rst = 1'b1;
    step("mid_rst");
    check("mid_rst_oe", oe, 1'b0);
    check("mid_rst_grant", grant, '0);
    rst = 1'b0;
    step("post_rst");
    check("post_rst_grant", grant, 4'b0001);

    // Randomised traffic against the model.
    repeat (400) begin
      rst    = ($urandom_range(0, 49) == 0);
      enable = ($urandom_range(0, 7) != 0);
      req    = N'($urandom);
      din    = {$urandom, $urandom};
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
